commit_trace_buffer: RTL
========================

// Module: commit_trace_buffer
// PURPOSE
//  Consumes the RISC-V core's architectural-effect outputs and packs each event into a timestamped 64-bit trace record.
//  Events are register writeback, data-memory write and data-memory read.
//  Records are buffered in a FWFT FIFO and drained over a valid/ready stream, so checkers and loggers need not sample the core.
//  Sits directly downstream of the riscv core, alongside data memory; overflow is flagged and counted, never stalls the core.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of 2, >= 4
//  LOG_X0  0   1: log reg_write_sig with reg_num==0; 0: discard those events
//  ADDR_W  9   memory address width (matches core addr port)
//  DATA_W  32  data width; fixed at 32 for the 64-bit record layout
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  enable         in   1       1 = capture events; 0 = ignore inputs, drain continues
//  reg_write_sig  in   1       core register writeback strobe
//  reg_num        in   5       destination register
//  reg_data       in   32      writeback value
//  wr             in   1       data-memory write strobe
//  rd             in   1       data-memory read strobe
//  addr           in   ADDR_W  data-memory address
//  wr_data        in   32      store data
//  rd_data        in   32      load data (valid in the cycle rd is high)
//  trace_valid    out  1       head record available
//  trace_ready    in   1       consumer accepts head record
//  trace_data     out  64      head record
//  fill_level     out  $clog2(DEPTH)+1  records held
//  overflow       out  1       sticky: at least one event dropped
//  drop_count     out  16      dropped events, saturating at 16'hFFFF
//  clear_overflow in   1       clears overflow and drop_count
// BEHAVIOUR
//  Reset: FIFO empty; stamp, drop_count, fill_level = 0; trace_valid = 0; overflow = 0; trace_data = 0.
//  Record layout: {stamp[15:0], type[1:0], 5'b0, idx[8:0], data[31:0]}.
//   Register write: type 2'b01, idx = {4'b0, reg_num}, data = reg_data.
//   Memory write: type 2'b10, idx = addr, data = wr_data.
//   Memory read: type 2'b11, idx = addr, data = rd_data.
//  stamp: 16-bit free-running counter; 0 in the first cycle after reset, +1 every cycle, wraps 16'hFFFF -> 0.
//   stamp counts regardless of enable.
//   The record carries the stamp of the cycle in which the event was sampled.
//  Memory event valid only when exactly one of wr and rd is high; wr&&rd together -> no memory event, not counted as a drop.
//  Per cycle, up to 2 events (1 memory, 1 register) are enqueued in order: memory first, then register.
//  Free slots = DEPTH - fill_level + (trace_valid && trace_ready); a same-cycle pop frees a slot for a push.
//  Fewer free slots than events: memory event takes the single slot, register event is dropped.
//   With 0 free slots, all events that cycle are dropped.
//  Each dropped event sets overflow and increments drop_count by 1 (saturating); up to 2 drops per cycle.
//  clear_overflow wins over older history only.
//   Same-cycle drops leave overflow = 1 and drop_count = number of drops in that cycle.
//  FWFT: a record written in cycle N appears on trace_data with trace_valid=1 in cycle N+1 (1-cycle latency).
//   trace_data holds stable while trace_valid && !trace_ready.
//  Pop when trace_valid && trace_ready; pointers wrap modulo DEPTH; fill_level exact every cycle (0..DEPTH).
//  enable=0: no events captured and no drops counted; draining and stamp unaffected.
//  Reset asserted mid-stream: contents discarded and all state returns to reset values on that edge.
//   trace_valid is 0 in the following cycle.
// TESTING
//  1. reg_write_sig, reg_num=5, reg_data=0x2A at stamp 3, trace_ready=1.
//     -> next cycle trace_valid=1, trace_data=64'h0003_4005_0000_002A.
//  2. wr=1, addr=9'h1F0, wr_data=0xDEADBEEF plus reg write x7=0x11, same cycle.
//     -> two records, memory (type 10) first, then register (type 01); both carry the same stamp.
//  3. trace_ready=0, one event per cycle for DEPTH+3 cycles.
//     -> fill_level=DEPTH, overflow=1, drop_count=3; raise trace_ready -> records drain in order.
//  4. FIFO holds DEPTH-1, mem+reg event together with no pop -> memory kept, drop_count+1.
//     Repeat with pop the same cycle -> both kept.
//  5. reg_write_sig with reg_num=0 and LOG_X0=0 -> nothing enqueued.
//     wr&&rd both high -> nothing enqueued, drop_count unchanged.
//  6. Reset asserted with 5 records queued -> next cycle trace_valid=0, fill_level=0, stamp restarts at 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: packs core writeback / memory events into timestamped
// 64-bit records and queues them in a first-word-fall-through FIFO.
module commit_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LOG_X0 = 0,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [63:0]                trace_data,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  input  logic                       clear_overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FREE_W = CNT_W + 1;
  localparam int unsigned IDX_W  = 9;

  logic [63:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       stamp_q, stamp_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;

  logic              pop_c;
  logic              mem_ev_c, reg_ev_c;
  logic [1:0]        n_ev_c, n_push_c, n_drop_c;
  logic [FREE_W-1:0] free_c;
  logic [63:0]       mem_rec_c, reg_rec_c, slot0_c, slot1_c;
  logic [16:0]       drop_sum_c;

  // Event qualification, record packing and slot allocation (memory first).
  always_comb begin
    pop_c     = (count_q != '0) && trace_ready;
    mem_ev_c  = enable && (wr ^ rd);
    reg_ev_c  = enable && reg_write_sig && ((LOG_X0 != 0) || (reg_num != 5'd0));
    mem_rec_c = {stamp_q, (wr ? 2'b10 : 2'b11), 5'b0, IDX_W'(addr),
                 (wr ? 32'(wr_data) : 32'(rd_data))};
    reg_rec_c = {stamp_q, 2'b01, 5'b0, 4'b0, reg_num, 32'(reg_data)};
    slot0_c   = mem_ev_c ? mem_rec_c : reg_rec_c;
    slot1_c   = reg_rec_c;
    n_ev_c    = {1'b0, mem_ev_c} + {1'b0, reg_ev_c};
    free_c    = FREE_W'(DEPTH) - FREE_W'(count_q) + FREE_W'(pop_c);
    n_push_c  = (free_c >= FREE_W'(n_ev_c)) ? n_ev_c : free_c[1:0];
    n_drop_c  = n_ev_c - n_push_c;
  end

  // Next-state for pointers, occupancy, stamp and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(n_push_c) - CNT_W'(pop_c);
    stamp_d    = stamp_q + 16'd1;
    drop_sum_c = {1'b0, (clear_overflow ? 16'd0 : drop_q)} + 17'(n_drop_c);
    drop_d     = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
    overflow_d = (clear_overflow ? 1'b0 : overflow_q) | (n_drop_c != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stamp_q    <= stamp_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage array carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (n_push_c != 2'd0) mem_q[wr_ptr_q] <= slot0_c;
      if (n_push_c == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= slot1_c;
    end
  end

  assign trace_valid = (count_q != '0);
  assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : 64'd0;
  assign fill_level  = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule
